// File: rtl/seven_seg_pkg.sv
// Shared types and sizes for the seven-segment scan controller.
package seven_seg_pkg;
   localparam int DIGIT_W    = 4;
   localparam int SEL_W      = 3;
   localparam int MAX_DIGITS = 8;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef digit_t digit_buf_t [MAX_DIGITS];
endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-DIV counter; tick is high during the terminal-count cycle.
module scan_prescaler #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Double-buffered 8-digit scan controller with frame-aligned commit.
// Optional SEVEN_SEG_SCAN_BLANK_EN adds per-digit blanking (blank_mask -> blank).
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [SEL_W-1:0]   wr_addr,
   input  logic [DIGIT_W-1:0] wr_data,
   input  logic               commit_req,
`ifdef SEVEN_SEG_SCAN_BLANK_EN
   input  logic [MAX_DIGITS-1:0] blank_mask,
   output logic               blank,
`endif
   output logic               commit_ack,
   output logic               commit_pend,
   output logic [DIGIT_W-1:0] num,
   output logic [SEL_W-1:0]   s,
   output logic               scan_tick
);
   localparam logic [SEL_W-1:0] S_LAST = SEL_W'(NUM_DIGITS - 1);
   localparam logic [SEL_W:0]   N_DIG  = (SEL_W+1)'(NUM_DIGITS);

   digit_buf_t shadow, active;
   logic       pre_tick, frame_end;

   scan_prescaler #(.DIV(REFRESH_DIV)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .tick (pre_tick)
   );

   assign frame_end = pre_tick && (s == S_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         s           <= '0;
         scan_tick   <= 1'b0;
         commit_ack  <= 1'b0;
         commit_pend <= 1'b0;
         for (int i = 0; i < MAX_DIGITS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         scan_tick  <= pre_tick;
         commit_ack <= frame_end & commit_pend;
         if (pre_tick) s <= frame_end ? '0 : s + SEL_W'(1);
         // A request landing on the serving edge is absorbed; one landing idle is kept for next frame.
         if (frame_end) begin
            commit_pend <= ~commit_pend & commit_req;
            if (commit_pend) active <= shadow;
         end else begin
            commit_pend <= commit_pend | commit_req;
         end
         if (wr_en && ({1'b0, wr_addr} < N_DIG)) shadow[wr_addr] <= wr_data;
      end
   end

   assign num = active[s];

`ifdef SEVEN_SEG_SCAN_BLANK_EN
   assign blank = blank_mask[s];
`endif
endmodule
